jtdsp16_pmem: RTL and testbench
===============================

JTDSP16_PMEM -- requirements
Module: jtdsp16_pmem

Interface
REQ-001 rst  input  1  reset; asynchronous, active-high.
REQ-002 clk  input  1  single system clock; all state on its rising edge.
REQ-003 cen  input  1  DSP clock enable; qualifies DSP-side use of rom_dout/rom_wait only.
REQ-004 rom_addr  input  16  word address from the ROM address unit (current PC).
REQ-005 rom_dout  output  16  instruction word for rom_addr, valid while rom_wait=0.
REQ-006 rom_wait  output  1  stall request; the DSP holds its PC while high.
REQ-007 prog_addr  output  17  external byte address.
REQ-008 prog_cs  output  1  external read request.
REQ-009 prog_data  input  8  external read data.
REQ-010 prog_ok  input  1  prog_data valid for the current prog_addr while prog_cs=1.

Function
REQ-011 Buffer of 2 entries, each with a valid bit, a 16-bit tag and a 16-bit data word.
REQ-012 Hit: rom_addr equals the tag of a valid entry; rom_dout = that entry's data and rom_wait=0, both combinational.
REQ-013 Miss: rom_wait=1 combinational; rom_dout holds its last driven value.
REQ-014 Word A maps to bytes: low byte at {A,0}, high byte at {A,1}.
REQ-015 FSM states: IDLE, LO, HI, FILL. The FSM advances on every clk, not gated by cen.
REQ-016 IDLE -> LO on a miss: latch fetch address F=rom_addr; prog_addr={F,0}; prog_cs=1.
REQ-017 LO: on prog_ok, capture the low byte, set prog_addr={F,1}, and go to HI.
REQ-018 HI: on prog_ok, capture the high byte, drop prog_cs, and go to FILL.
REQ-019 FILL: write {F, data} into the entry not holding rom_addr (the LRU entry when neither does), set it valid, and go to IDLE; total miss latency is 2 prog_ok handshakes plus 1 clk.
REQ-020 prog_ok while prog_cs=0, or in IDLE/FILL, is ignored.
REQ-021 If rom_addr changes during a fetch, the fetch completes and fills with F; on return to IDLE a new miss starts if needed. No abort.
REQ-022 A FILL whose tag equals an already valid entry overwrites that entry; duplicate tags never coexist.
REQ-023 Address arithmetic wraps: F+1 of 16'hFFFF is 16'h0000.
REQ-024 The LRU pointer updates on every cen cycle with a hit, pointing away from the hit entry.

Reset
REQ-025 On reset: both valid bits=0, tags=0, data=0; FSM=IDLE; prog_cs=0; prog_addr=0; rom_dout=0; LRU=entry 0.
REQ-026 Reset asserted mid-fetch abandons the fetch immediately; no partial fill occurs.
REQ-027 After reset release, the first cycle is a miss on rom_addr (rom_wait=1).

Configuration
REQ-028 Macro JTDSP16_PMEM_PREFETCH_EN:
- Defined: in IDLE with no miss, if F+1 (of the last demand fill) is not buffered, fetch it through LO/HI/FILL into the entry not holding rom_addr.
- Prefetch in progress and a miss occurs: the prefetch completes first, then the demand fetch starts.
- Not defined: demand fetches only; the FSM leaves IDLE only on a miss.

Structure
REQ-029 Package jtdsp16_pkg holds the FSM state encoding constants and the entry count (2).
REQ-030 One sub-module, jtdsp16_pmem_buf: the 2-entry tag/data/valid store with LRU and hit logic. The FSM and external handshake stay in jtdsp16_pmem.

Verification
REQ-031 Reset, rom_addr=16'h0000, memory bytes 0x34@0, 0x12@1, prog_ok one clk after each request -> prog_addr 0 then 1; rom_wait falls after FILL; rom_dout=16'h1234.
REQ-032 Prefetch enabled, PC steps 0x0010 -> 0x0011 after fill -> no rom_wait at 0x0011; prog_addr visits 0x00022 and 0x00023.
REQ-033 Prefetch enabled, PC alternating 0x0100/0x0101 after both are filled -> rom_wait stays 0 and prog_cs stays 0 for 20 cycles.
REQ-034 rom_addr changes 0x0200 -> 0x0300 during LO -> 0x0200 fill completes, then a fetch of 0x0300 starts; rom_dout is correct for 0x0300.
REQ-035 rst pulse while in HI -> prog_cs=0 in the same cycle; both entries invalid; the next access misses.
REQ-036 Prefetch enabled, fill of 16'hFFFF -> the prefetch uses prog_addr 17'h00000/17'h00001 (wrap).

Source files
------------

// File: rtl/jtdsp16_pkg.sv
// Shared constants for the JTDSP16 program-memory fetch buffer.
// Optional next-word prefetch is enabled with JTDSP16_PMEM_PREFETCH_EN.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FILL = 2'd3
  } pmem_state_t;

  localparam int PMEM_ENTRIES = 2;

endpackage

// File: rtl/jtdsp16_pmem_buf.sv
// Two-entry instruction buffer: tag/data/valid store, hit lookup and LRU victim choice.
// JTDSP16_PMEM_PREFETCH_EN adds a second lookup port used to test the prefetch address.
module jtdsp16_pmem_buf
  import jtdsp16_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [15:0] rom_addr,
  output logic        hit,
  output logic [15:0] hit_data,
  input  logic        wr_en,
  input  logic [15:0] wr_tag,
  input  logic [15:0] wr_data
`ifdef JTDSP16_PMEM_PREFETCH_EN
  ,
  input  logic [15:0] probe_addr,
  output logic        probe_hit
`endif
);

  logic [PMEM_ENTRIES-1:0] valid;
  logic [PMEM_ENTRIES-1:0] match;
  logic [PMEM_ENTRIES-1:0] dup;
  logic [15:0]             tag  [PMEM_ENTRIES];
  logic [15:0]             data [PMEM_ENTRIES];
  logic                    lru;
  logic                    hit_idx;
  logic                    wr_sel;

  always_comb begin
    match = '0;
    dup   = '0;
    for (int i = 0; i < PMEM_ENTRIES; i++) begin
      match[i] = valid[i] && (tag[i] == rom_addr);
      dup[i]   = valid[i] && (tag[i] == wr_tag);
    end
  end

  assign hit      = |match;
  assign hit_idx  = match[1];
  assign hit_data = data[hit_idx];

`ifdef JTDSP16_PMEM_PREFETCH_EN
  assign probe_hit = (valid[0] && (tag[0] == probe_addr)) ||
                     (valid[1] && (tag[1] == probe_addr));
`endif

  // Victim: an existing copy of the tag wins, then the entry not feeding the DSP, then LRU
  always_comb begin
    wr_sel = lru;
    if (hit) wr_sel = ~hit_idx;
    if (dup[0])      wr_sel = 1'b0;
    else if (dup[1]) wr_sel = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      lru   <= 1'b0;
      for (int i = 0; i < PMEM_ENTRIES; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (cen && hit) lru <= ~hit_idx;
      if (wr_en) begin
        valid[wr_sel] <= 1'b1;
        tag[wr_sel]   <= wr_tag;
        data[wr_sel]  <= wr_data;
      end
    end
  end

endmodule

// File: rtl/jtdsp16_pmem.sv
// JTDSP16 program memory front end: serves instruction words from a 2-entry buffer and refills
// it from a byte-wide external ROM. JTDSP16_PMEM_PREFETCH_EN enables next-word prefetch.
module jtdsp16_pmem
  import jtdsp16_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [15:0] rom_addr,
  output logic [15:0] rom_dout,
  output logic        rom_wait,
  output logic [16:0] prog_addr,
  output logic        prog_cs,
  input  logic [7:0]  prog_data,
  input  logic        prog_ok
);

  pmem_state_t state, state_nx;
  logic [15:0] fetch_addr, fetch_nx;
  logic [15:0] dout_q, hit_data;
  logic [7:0]  lo_byte, lo_nx, hi_byte, hi_nx;
  logic [16:0] paddr_nx;
  logic        pcs_nx, hit, wr_en;

`ifdef JTDSP16_PMEM_PREFETCH_EN
  logic [15:0] last_fill, last_nx, pf_addr;
  logic        pf_armed, armed_nx, is_pf, is_pf_nx, probe_hit;

  assign pf_addr = last_fill + 16'd1;
`endif

  jtdsp16_pmem_buf u_buf (
    .rst        (rst),
    .clk        (clk),
    .cen        (cen),
    .rom_addr   (rom_addr),
    .hit        (hit),
    .hit_data   (hit_data),
    .wr_en      (wr_en),
    .wr_tag     (fetch_addr),
    .wr_data    ({hi_byte, lo_byte})
`ifdef JTDSP16_PMEM_PREFETCH_EN
    ,
    .probe_addr (pf_addr),
    .probe_hit  (probe_hit)
`endif
  );

  assign rom_wait = ~hit;
  assign rom_dout = hit ? hit_data : dout_q;

  always_comb begin
    state_nx = state;
    fetch_nx = fetch_addr;
    lo_nx    = lo_byte;
    hi_nx    = hi_byte;
    paddr_nx = prog_addr;
    pcs_nx   = prog_cs;
    wr_en    = 1'b0;
`ifdef JTDSP16_PMEM_PREFETCH_EN
    last_nx  = last_fill;
    armed_nx = pf_armed;
    is_pf_nx = is_pf;
`endif
    case (state)
      ST_IDLE: begin
        if (!hit) begin
          fetch_nx = rom_addr;
          paddr_nx = {rom_addr, 1'b0};
          pcs_nx   = 1'b1;
          state_nx = ST_LO;
`ifdef JTDSP16_PMEM_PREFETCH_EN
          is_pf_nx = 1'b0;
`endif
        end
`ifdef JTDSP16_PMEM_PREFETCH_EN
        else if (pf_armed && !probe_hit) begin
          fetch_nx = pf_addr;
          paddr_nx = {pf_addr, 1'b0};
          pcs_nx   = 1'b1;
          state_nx = ST_LO;
          is_pf_nx = 1'b1;
        end
`endif
      end
      ST_LO: begin
        if (prog_ok) begin
          lo_nx    = prog_data;
          paddr_nx = {fetch_addr, 1'b1};
          state_nx = ST_HI;
        end
      end
      ST_HI: begin
        if (prog_ok) begin
          hi_nx    = prog_data;
          pcs_nx   = 1'b0;
          state_nx = ST_FILL;
        end
      end
      ST_FILL: begin
        wr_en    = 1'b1;
        state_nx = ST_IDLE;
`ifdef JTDSP16_PMEM_PREFETCH_EN
        // Only demand fills move the prefetch target, so a prefetch never chains
        if (!is_pf) begin
          last_nx  = fetch_addr;
          armed_nx = 1'b1;
        end
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      fetch_addr <= '0;
      lo_byte    <= '0;
      hi_byte    <= '0;
      prog_addr  <= '0;
      prog_cs    <= 1'b0;
      dout_q     <= '0;
`ifdef JTDSP16_PMEM_PREFETCH_EN
      last_fill  <= '0;
      pf_armed   <= 1'b0;
      is_pf      <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      fetch_addr <= fetch_nx;
      lo_byte    <= lo_nx;
      hi_byte    <= hi_nx;
      prog_addr  <= paddr_nx;
      prog_cs    <= pcs_nx;
      dout_q     <= rom_dout;
`ifdef JTDSP16_PMEM_PREFETCH_EN
      last_fill  <= last_nx;
      pf_armed   <= armed_nx;
      is_pf      <= is_pf_nx;
`endif
    end
  end

endmodule

// File: tb/tb_jtdsp16_pmem.sv
// Directed bench for jtdsp16_pmem with a byte ROM responder and expected-value queues.
// Builds with or without JTDSP16_PMEM_PREFETCH_EN; each build runs the matching sequence.
module tb_jtdsp16_pmem;

  logic        rst, clk, cen;
  logic [15:0] rom_addr, rom_dout;
  logic        rom_wait;
  logic [16:0] prog_addr;
  logic        prog_cs;
  logic [7:0]  prog_data;
  logic        prog_ok;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  logic [16:0] pa_q  [$];
  logic        spurious = 1'b0;
  logic [15:0] last_dout;

  jtdsp16_pmem dut (
    .rst       (rst),
    .clk       (clk),
    .cen       (cen),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .rom_wait  (rom_wait),
    .prog_addr (prog_addr),
    .prog_cs   (prog_cs),
    .prog_data (prog_data),
    .prog_ok   (prog_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a * 16'd7 + 16'h1234;
  endfunction

  function automatic logic [7:0] byte_of(input logic [16:0] ba);
    logic [15:0] w;
    w = word_of(ba[16:1]);
    return ba[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_fetch(input logic [15:0] a);
    pa_q.push_back({a, 1'b0});
    pa_q.push_back({a, 1'b1});
  endtask

  // Byte ROM: answers each new request one clk later, then leaves a one-cycle gap
  initial begin
    prog_ok   = 1'b0;
    prog_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !prog_cs) begin
        prog_ok = spurious && !rst;
      end else if (prog_ok) begin
        prog_ok = 1'b0;
      end else begin
        n_chk++;
        assert (pa_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_req: observed prog_addr %h expected no request", prog_addr);
        end
        if (pa_q.size() != 0) check("prog_addr", prog_addr, pa_q.pop_front());
        prog_data = byte_of(prog_addr);
        prog_ok   = 1'b1;
      end
    end
  end

  // Called right after a negedge; returns one negedge after the word is consumed by a clk edge
  task automatic access(input logic [15:0] a, input int exp_lat, input string tag, input bit pf);
    int          n = 0;
    logic [15:0] e;
    rom_addr = a;
    exp_q.push_back(word_of(a));
    if (exp_lat > 0) push_fetch(a);
    if (pf) push_fetch(a + 16'd1);
    #1;
    if (exp_lat > 0) begin
      check({tag, "_miss"}, rom_wait, 1);
      check({tag, "_hold"}, rom_dout, last_dout);
    end
    while (rom_wait && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    check({tag, "_ready"}, rom_wait, 0);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_dout"}, rom_dout, e);
    last_dout = e;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((pa_q.size() != 0 || prog_cs) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, (n < 60), 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    cen       = 1'b1;
    rom_addr  = 16'h0000;
    last_dout = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_prog_cs", prog_cs, 0);
    check("rst_prog_addr", prog_addr, 17'h00000);
    check("rst_rom_dout", rom_dout, 16'h0000);
    check("rst_rom_wait", rom_wait, 1);
    rst = 1'b0;

`ifdef JTDSP16_PMEM_PREFETCH_EN
    access(16'h0000, 5, "first", 1'b1);
    check("first_word", last_dout, 16'h1234);
    drain("pf0001");
    access(16'h0010, 5, "pc0010", 1'b1);
    drain("pf0011");
    access(16'h0011, 0, "pc0011", 1'b0);
    access(16'h0100, 5, "pc0100", 1'b1);
    drain("pf0101");
    for (int i = 0; i < 20; i++) begin
      rom_addr = i[0] ? 16'h0101 : 16'h0100;
      #1;
      check("alt_wait", rom_wait, 0);
      check("alt_cs", prog_cs, 0);
      check("alt_dout", rom_dout, word_of(rom_addr));
      @(negedge clk);
    end
    last_dout = word_of(16'h0101);
    access(16'hFFFF, 5, "pcffff", 1'b1);
    drain("pfwrap");
    access(16'h0000, 0, "wrap0", 1'b0);
`else
    access(16'h0000, 5, "first", 1'b0);
    check("first_word", last_dout, 16'h1234);
    access(16'h0000, 0, "hit0", 1'b0);
    access(16'h0055, 5, "miss55", 1'b0);
    access(16'h0000, 0, "hit0b", 1'b0);
    access(16'h0077, 5, "miss77", 1'b0);
    access(16'h0000, 0, "hit0c", 1'b0);
    access(16'h0055, 5, "lru55", 1'b0);
    access(16'h0000, 0, "keep0", 1'b0);

    spurious = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("spur_wait", rom_wait, 0);
      check("spur_cs", prog_cs, 0);
    end
    spurious = 1'b0;
    repeat (2) @(negedge clk);

    access(16'hFFFF, 5, "ffff", 1'b0);

    // PC moves while the low byte is outstanding: old fetch completes, then the new one
    rom_addr = 16'h0200;
    push_fetch(16'h0200);
    push_fetch(16'h0300);
    @(negedge clk);
    rom_addr = 16'h0300;
    n = 0;
    while (rom_wait && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("move_lat", n, 9);
    check("move_dout", rom_dout, word_of(16'h0300));
    last_dout = word_of(16'h0300);
    @(negedge clk);

    rom_addr = 16'h0400;
    pa_q.push_back({16'h0400, 1'b0});
    repeat (2) @(negedge clk);
    check("hi_cs", prog_cs, 1);
    check("hi_addr", prog_addr, {16'h0400, 1'b1});
    rst = 1'b1;
    #1;
    check("midrst_cs", prog_cs, 0);
    check("midrst_addr", prog_addr, 17'h00000);
    check("midrst_wait", rom_wait, 1);
    check("midrst_dout", rom_dout, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    last_dout = 16'h0000;
    access(16'h0300, 5, "post_rst300", 1'b0);
    access(16'hFFFF, 5, "post_rstffff", 1'b0);
`endif

    check("fetch_q_empty", pa_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
